// File: rtl/blink_seq_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | blink_seq_pkg : mode/state encodings and tick divider helper              |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
package blink_seq_pkg;

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_BURST = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ON_PH  = 2'd1,
    ST_OFF_PH = 2'd2
  } state_e;

  function automatic int calc_div(input int freq_hz, input int tick_hz);
    return freq_hz / tick_hz;
  endfunction

endpackage
`default_nettype wire

// File: rtl/blink_sequencer_tick_gen.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tick_gen : clearable prescaler emitting a one-cycle tick every DIV clocks |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int          PRE_W = $clog2(DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

  generate
    if (DIV < 2) begin : g_div_bad
      $error("tick_gen: DIV must be at least 2");
    end
  endgenerate

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  assign tick_o = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = pre_q + PRE_ONE;
    if (clr_i || tick_o) begin
      pre_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/blink_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | blink_sequencer : command-driven LED off/on/blink/burst controller        |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module blink_sequencer
  import blink_seq_pkg::*;
#(
  parameter int FREQUENCY = 25_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HALF_W    = 8,
  parameter int CNT_W     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_mode_i,
  input  logic [HALF_W-1:0] cmd_half_i,
  input  logic [CNT_W-1:0]  cmd_count_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              led_o
);

  localparam int                DIV      = calc_div(FREQUENCY, TICK_HZ);
  localparam logic [HALF_W-1:0] HALF_ONE = HALF_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HALF_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]  pulse_q, pulse_d;
  logic              led_q, led_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              tick;
  logic              phase_end;

  // Ready depends only on the registered busy flag.
  assign cmd_ready_o = ~busy_q;
  assign accept      = cmd_valid_i & cmd_ready_o;
  assign phase_end   = tick && (phase_q == (half_q - HALF_ONE));

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign led_o  = led_q;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (accept),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    half_d  = half_q;
    count_d = count_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    led_d   = led_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (accept) begin
      // A new command always wins over a coincident abort.
      mode_d  = cmd_mode_i;
      half_d  = (cmd_half_i == '0) ? HALF_ONE : cmd_half_i;
      count_d = cmd_count_i;
      phase_d = '0;
      pulse_d = '0;
      busy_d  = 1'b0;
      case (cmd_mode_i)
        MODE_OFF: begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
        end
        MODE_ON: begin
          state_d = ST_IDLE;
          led_d   = 1'b1;
        end
        MODE_BLINK: begin
          state_d = ST_ON_PH;
          led_d   = 1'b1;
        end
        default: begin
          if (cmd_count_i == '0) begin
            state_d = ST_IDLE;
            led_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ON_PH;
            led_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
      endcase
    end else if (abort_i) begin
      state_d = ST_IDLE;
      led_d   = 1'b0;
      busy_d  = 1'b0;
    end else if (tick && (state_q != ST_IDLE)) begin
      if (phase_end) begin
        phase_d = '0;
        if (state_q == ST_ON_PH) begin
          state_d = ST_OFF_PH;
          led_d   = 1'b0;
        end else if ((mode_q == MODE_BURST) && (pulse_q == (count_q - CNT_ONE))) begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ON_PH;
          led_d   = 1'b1;
          pulse_d = pulse_q + CNT_ONE;
        end
      end else begin
        phase_d = phase_q + HALF_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_OFF;
      half_q  <= HALF_ONE;
      count_q <= '0;
      phase_q <= '0;
      pulse_q <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      half_q  <= half_d;
      count_q <= count_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_blink_sequencer.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_blink_sequencer : directed self-checking bench, DIV = 10               |
// | Revision 1.0                                                              |
// +---------------------------------------------------------------------------+
module tb_blink_sequencer;

  localparam int HALF_W = 8;
  localparam int CNT_W  = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [1:0]        cmd_mode_i;
  logic [HALF_W-1:0] cmd_half_i;
  logic [CNT_W-1:0]  cmd_count_i;
  logic              abort_i;
  logic              busy_o;
  logic              done_o;
  logic              led_o;

  int checks = 0;
  int errors = 0;

  blink_sequencer #(
    .FREQUENCY (1000),
    .TICK_HZ   (100),
    .HALF_W    (HALF_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_mode_i  (cmd_mode_i),
    .cmd_half_i  (cmd_half_i),
    .cmd_count_i (cmd_count_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .led_o       (led_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents one command for a single edge; afterwards the bench sits 1 time
  // unit after the accepting edge (sample index k = 0).
  task automatic send(input logic [1:0] mode, input int half, input int cnt);
    cmd_valid_i = 1'b1;
    cmd_mode_i  = mode;
    cmd_half_i  = HALF_W'(half);
    cmd_count_i = CNT_W'(cnt);
    step();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int ndone;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_mode_i  = 2'd0;
    cmd_half_i  = '0;
    cmd_count_i = '0;
    abort_i     = 1'b0;

    // Asynchronous reset in the middle of a clock period.
    #12;
    rst_i = 1'b0;
    #1;
    chk("rst_led",   led_o,       1'b0);
    chk("rst_ready", cmd_ready_o, 1'b1);
    chk("rst_busy",  busy_o,      1'b0);
    chk("rst_done",  done_o,      1'b0);
    step();
    #2;
    rst_i = 1'b1;
    step();
    step();

    // ON with one-cycle latency.
    chk("on_pre_led", led_o, 1'b0);
    send(2'd1, 1, 0);
    chk("on_led", led_o, 1'b1);
    chk("on_busy", busy_o, 1'b0);

    // BLINK half=3: 30 high / 30 low, four full periods.
    send(2'd2, 3, 0);
    for (int k = 0; k < 240; k++) begin
      chk($sformatf("blink3_led_k%0d", k), led_o, ((k / 30) % 2) == 0);
      chk($sformatf("blink3_ready_k%0d", k), cmd_ready_o, 1'b1);
      step();
    end

    // BLINK half=3, OFF issued at cycle 45.
    send(2'd2, 3, 0);
    for (int k = 0; k < 45; k++) step();
    send(2'd0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("blink_off_led_k%0d", k), led_o, 1'b0);
      step();
    end

    // Preempt BLINK during its high phase.
    send(2'd2, 3, 0);
    for (int k = 0; k < 15; k++) step();
    chk("preempt_led_hi", led_o, 1'b1);
    send(2'd0, 1, 0);
    chk("preempt_led_lo", led_o, 1'b0);

    // BURST half=2 count=3: 3 x (20 high / 20 low), done at k=120.
    send(2'd3, 2, 3);
    ndone = 0;
    for (int k = 0; k < 120; k++) begin
      chk($sformatf("burst_led_k%0d", k), led_o, ((k / 20) % 2) == 0);
      chk($sformatf("burst_busy_k%0d", k), busy_o, 1'b1);
      chk($sformatf("burst_ready_k%0d", k), cmd_ready_o, 1'b0);
      if (done_o === 1'b1) ndone++;
      step();
    end
    chk("burst_end_done",  done_o,      1'b1);
    chk("burst_end_busy",  busy_o,      1'b0);
    chk("burst_end_led",   led_o,       1'b0);
    chk("burst_end_ready", cmd_ready_o, 1'b1);
    if (done_o === 1'b1) ndone++;
    for (int k = 0; k < 20; k++) begin
      step();
      chk($sformatf("burst_after_led_k%0d", k), led_o, 1'b0);
      if (done_o === 1'b1) ndone++;
    end
    chk("burst_done_pulses", ndone, 1);

    // BURST count=0: immediate done, no pulses, never busy.
    send(2'd3, 2, 0);
    chk("burst0_done", done_o, 1'b1);
    chk("burst0_led",  led_o,  1'b0);
    chk("burst0_busy", busy_o, 1'b0);
    for (int k = 1; k < 30; k++) begin
      step();
      chk($sformatf("burst0_done_k%0d", k), done_o, 1'b0);
      chk($sformatf("burst0_led_k%0d", k), led_o, 1'b0);
      chk($sformatf("burst0_busy_k%0d", k), busy_o, 1'b0);
    end

    // BLINK half=0 behaves as half=1.
    send(2'd2, 0, 0);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("blink0_led_k%0d", k), led_o, ((k / 10) % 2) == 0);
      step();
    end

    // Abort during the second pulse of BURST half=2 count=5.
    send(2'd3, 2, 5);
    for (int k = 0; k < 45; k++) step();
    chk("abort_pre_led",  led_o,  1'b1);
    chk("abort_pre_busy", busy_o, 1'b1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_led",   led_o,       1'b0);
    chk("abort_busy",  busy_o,      1'b0);
    chk("abort_ready", cmd_ready_o, 1'b1);
    ndone = 0;
    for (int k = 0; k < 200; k++) begin
      if (done_o === 1'b1) ndone++;
      chk($sformatf("abort_after_led_k%0d", k), led_o, 1'b0);
      step();
    end
    chk("abort_no_done", ndone, 0);

    // Abort coincident with an ON accept: the command wins.
    abort_i = 1'b1;
    send(2'd1, 1, 0);
    abort_i = 1'b0;
    chk("abort_on_led", led_o, 1'b1);
    // Abort alone in IDLE forces the LED off.
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_idle_led", led_o, 1'b0);

    // Reset asserted mid-burst.
    send(2'd3, 2, 2);
    for (int k = 0; k < 10; k++) step();
    chk("mid_pre_led",  led_o,  1'b1);
    chk("mid_pre_busy", busy_o, 1'b1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_led",   led_o,       1'b0);
    chk("mid_rst_busy",  busy_o,      1'b0);
    chk("mid_rst_ready", cmd_ready_o, 1'b1);
    chk("mid_rst_done",  done_o,      1'b0);
    step();
    chk("mid_rst_hold_done", done_o, 1'b0);
    rst_i = 1'b1;
    step();

    // Fresh BURST after reset: full-length first phase.
    send(2'd3, 2, 1);
    for (int k = 0; k < 40; k++) begin
      chk($sformatf("post_rst_led_k%0d", k), led_o, k < 20);
      chk($sformatf("post_rst_busy_k%0d", k), busy_o, 1'b1);
      chk($sformatf("post_rst_done_k%0d", k), done_o, 1'b0);
      step();
    end
    chk("post_rst_done", done_o, 1'b1);
    chk("post_rst_busy_end", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/blink_sequencer.md
Name: blink_sequencer

Overview:
- Command-driven LED pattern controller that sequences a single LED output through static off, static on, continuous blink and counted bursts.
- Timing is derived from a shared tick prescaler, so periods are set in ticks rather than raw clock cycles.
- Sits between a host or control FSM and a board LED pin.
- Supersedes free-running fixed-rate blinking wherever software must choose the pattern at run time.

Parameters:
- FREQUENCY, 25E6: clk_i frequency in Hz.
- TICK_HZ, 100: tick rate in Hz. DIV = FREQUENCY/TICK_HZ clock cycles per tick; DIV must be >= 2, checked at elaboration.
- HALF_W, 8: width of the half-period field, in ticks.
- CNT_W, 4: width of the burst pulse count.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command can be accepted.
- cmd_mode_i  in  2  0 = OFF, 1 = ON, 2 = BLINK, 3 = BURST.
- cmd_half_i  in  HALF_W  on-time and off-time, in ticks (0 treated as 1).
- cmd_count_i  in  CNT_W  number of pulses for BURST.
- abort_i  in  1  cancel the current pattern.
- busy_o  out  1  high while a BURST is executing.
- done_o  out  1  one-cycle pulse when a BURST completes normally.
- led_o  out  1  LED drive, registered.

Behaviour:
- Reset (rst_i = 0, async): state IDLE; led_o=0, cmd_ready_o=1, busy_o=0, done_o=0; prescaler, phase counter and pulse counter all 0.
- States: IDLE, ON_PH, OFF_PH.
- cmd_ready_o = 1 in every condition except BURST executing. It is derived from registered state only; no combinational path from cmd_valid_i or abort_i.
- Accept: cmd_valid_i & cmd_ready_o on a rising edge. Mode, half (0 forced to 1) and count are latched. Prescaler and phase counter clear on the same edge.
- The new pattern is visible on led_o in the cycle after accept (1-cycle latency).
- OFF: state IDLE, led_o=0. ON: state IDLE, led_o=1.
- BLINK: ON_PH with led_o=1 for half ticks, then OFF_PH with led_o=0 for half ticks; repeats forever. A new command preempts it at any time.
- BURST:
  - If count=0: no pulses; done_o pulses 1 cycle after accept; state IDLE with led_o=0; busy_o never rises.
  - Otherwise: busy_o=1 from the cycle after accept. Runs count on/off pairs, then goes to IDLE with led_o=0. done_o pulses in the first IDLE cycle, and busy_o falls in that same cycle.
- Phase timing: each phase lasts exactly half*DIV clock cycles. The tick fires when prescaler == DIV-1, and the prescaler then wraps to 0. A phase ends on the tick where phase_cnt == half-1, and the phase counter wraps to 0.
- abort_i = 1: at the next edge go to IDLE with led_o=0 and busy_o=0; done_o is not asserted.
  - If abort_i and a command accept occur on the same edge, the command wins and is executed.
  - Abort in IDLE only forces led_o=0.
- Counters saturate nowhere: pulse counter width CNT_W, phase counter width HALF_W, prescaler width $clog2(DIV).
- Reset asserted mid-burst: immediate return to reset values; no done_o.

Decomposition:
- Package blink_seq_pkg holds:
  - the mode encoding constants (MODE_OFF=0, MODE_ON=1, MODE_BLINK=2, MODE_BURST=3);
  - the state encoding;
  - a DIV computation function.
- Sub-module tick_gen: prescaler with clear input, parameter DIV, one-cycle tick_o output. It is reusable by other timed blocks.

Test Plan (FREQUENCY=1000, TICK_HZ=100, so DIV=10):
- Reset then idle: rst_i=0 mid-cycle -> led_o=0, cmd_ready_o=1, busy_o=0 immediately. Issue ON -> led_o=1 one cycle after accept.
- BLINK half=3: led_o alternates 30 cycles high, 30 cycles low, for at least 4 periods. Issue OFF at cycle 45 -> led_o=0 next cycle and stays low.
- BURST half=2, count=3: 3 pulses of 20 high / 20 low. busy_o high for 120 cycles and cmd_ready_o low throughout. Exactly one done_o pulse; led_o=0 afterwards.
- BURST count=0 -> done_o one cycle after accept, led_o never rises. BLINK half=0 -> behaves as half=1 (10/10 cycles).
- abort_i during the second pulse of a BURST count=5 -> next cycle IDLE, led_o=0, busy_o=0, no done_o. Abort coincident with an ON accept -> led_o=1.
- Assert rst_i mid-BURST -> outputs at reset values asynchronously. After release, a new BURST runs a full-length first phase.
